ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

AHB-lite memory slave that consumes the transfers driven by the team's behavioural AHB master. It is selected by the external decoder for the 0xC200_0000 region. It holds a small word-addressed register memory, inserts a configurable number of wait states, and returns a two-cycle ERROR response for transfers it does not support. HRESP is 2 bits wide so it matches the master's response checks.

## Interface
Parameters:
- ADDR_WIDTH, default 4: word-index bits; memory depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_STATES, default 1, legal range 0..3: HREADYOUT-low cycles inserted in every OKAY data phase.

Ports:
- HCLK  in  1  bus clock; all state updates on the rising edge.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  transfer address; bits [19:0] are the offset, upper bits are ignored.
- HTRANS  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  2  transfer size; only 2'b10 (32-bit) is supported.
- HWDATA  in  32  write data, valid during the data phase.
- HREADY  in  1  bus-level ready; an address phase is sampled only when this is 1.
- HREADYOUT  out  1  slave ready.
- HRESP  out  2  response: OKAY=00, ERROR=01.
- HRDATA  out  32  read data.

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY at a rising edge. On accept, capture HWRITE and the word index HADDR[ADDR_WIDTH+1:2].
- Error condition, evaluated at accept. Any one of these triggers ERROR:
  - HSIZE != 2'b10.
  - HADDR[1:0] != 0.
  - HADDR[19:ADDR_WIDTH+2] != 0 (offset outside the memory).
- IDLE/BUSY transfers, unselected cycles, and cycles with HREADY=0 are not accepted. They get HREADYOUT=1 and HRESP=OKAY.
- FSM states:
  - IDLE: no data phase pending.
  - WAIT: wait counter > 0.
  - DATA: final OKAY data-phase cycle.
  - ERR1, ERR2: the two ERROR cycles.
- FSM transitions:
  - Accept without error → WAIT with counter = WAIT_STATES, or → DATA directly if WAIT_STATES = 0.
  - Accept with error → ERR1.
  - WAIT: counter decrements each cycle; when it reaches 1 and decrements, go → DATA.
  - ERR1 → ERR2.
  - DATA or ERR2 → IDLE, unless a new transfer is accepted in the same cycle. In that case go straight to that transfer's first state (pipelined back-to-back).
- Outputs by state:
  - IDLE: HREADYOUT=1, HRESP=00.
  - WAIT: HREADYOUT=0, HRESP=00.
  - DATA: HREADYOUT=1, HRESP=00.
  - ERR1: HREADYOUT=0, HRESP=01.
  - ERR2: HREADYOUT=1, HRESP=01.
- Write: mem[idx] <= HWDATA at the rising edge that ends DATA. Errored writes never modify memory.
- Read: in DATA with a read captured, HRDATA = mem[idx] (combinational). In all other states HRDATA = 32'h0.
- Read-after-write to the same index, back-to-back: the read returns the new data, because the write commits before the read's DATA cycle.
- Reset, including mid-transfer:
  - FSM goes to IDLE and the wait counter to 0.
  - A pending write is discarded.
  - All memory words are cleared to 0.

## Timing
- Reset values: HREADYOUT=1, HRESP=2'b00, HRDATA=32'h0, all memory = 0.
- OKAY transfer: the data phase lasts WAIT_STATES+1 cycles after the accept edge, and HREADYOUT is low for the first WAIT_STATES of them.
- ERROR transfer: always 2 cycles, independent of WAIT_STATES. HRESP=ERROR is held for both cycles and HREADYOUT goes high only in the second.
- An address phase presented while HREADYOUT=0 is ignored. The master holds it until HREADY=1.
- Sustained NONSEQ throughput: one transfer per WAIT_STATES+1 cycles, with no idle gap between transfers.

## Test plan
- Reset, then IDLE traffic → HREADYOUT=1, HRESP=00, HRDATA=0. A read of 0xC200_0000 returns 0x0000_0000.
- WAIT_STATES=1: write 0x0000_1234 to 0xC200_0010, then read 0xC200_0010 back-to-back.
  - Required: each data phase has 1 low-ready cycle.
  - Required: the read returns 0x0000_1234.
- WAIT_STATES=0: write 0xDEAD_BEEF to index 15 (0xC200_003C), then read it.
  - Required: zero wait on both transfers.
  - Required: the read returns 0xDEAD_BEEF.
- Error cases:
  - Write to 0xC200_0040 (out of range), then HSIZE=2'b01 at 0xC200_0004, then unaligned 0xC200_0002.
  - Required: each gets ERR1 (HREADYOUT=0, HRESP=01) then ERR2 (HREADYOUT=1, HRESP=01).
  - Required: memory is unchanged.
- WAIT_STATES=3: assert HRESETn=0 during the second wait cycle of a write of 0x5555_AAAA to 0xC200_0008.
  - Required: outputs return to reset values immediately.
  - Required: a subsequent read of 0xC200_0008 returns 0.
- HSEL=1 with HTRANS=BUSY and with HTRANS=NONSEQ while HREADY=0 → no accept, no memory change, OKAY with zero wait.

Source files
------------

// File: rtl/ahb_mem_slave_if.sv
// rtl/ahb_mem_slave_if.sv - AHB-lite bus bundle between master and memory slave
interface ahb_mem_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [1:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_mem_slave.sv
// rtl/ahb_mem_slave.sv - AHB-lite word memory slave with wait states and two-cycle ERROR
module ahb_mem_slave #(
  parameter int ADDR_WIDTH  = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_mem_slave_if.slave  bus
);
  localparam int         DEPTH = 1 << ADDR_WIDTH;
  localparam logic [1:0] WS    = 2'(WAIT_STATES);
  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t                state;
  logic [1:0]            wait_cnt;
  logic                  wr_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  ready_q;
  logic [1:0]            resp_q;
  logic [31:0]           mem [DEPTH];

  logic        accept;
  logic        bad;
  logic [19:0] offset;
  logic        unused_bits;

  assign offset      = bus.HADDR[19:0];
  assign unused_bits = ^{bus.HADDR[31:20], bus.HTRANS[0]};

  // ready_q gates accept so an address held during our own wait cycles is ignored
  assign accept = bus.HSEL & bus.HTRANS[1] & bus.HREADY & ready_q;
  assign bad    = (bus.HSIZE != 2'b10) | (offset[1:0] != 2'b00) |
                  ((offset >> (ADDR_WIDTH + 2)) != 20'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      wait_cnt <= 2'd0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      ready_q  <= 1'b1;
      resp_q   <= OKAY;
    end else begin
      case (state)
        S_WAIT: begin
          if (wait_cnt == 2'd1) begin
            state    <= S_DATA;
            wait_cnt <= 2'd0;
            ready_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all present HREADYOUT=1, so a pipelined accept may land here
          if (accept) begin
            wr_q  <= bus.HWRITE;
            idx_q <= bus.HADDR[ADDR_WIDTH+1:2];
            if (bad) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= ERROR;
            end else if (WS == 2'd0) begin
              state   <= S_DATA;
              ready_q <= 1'b1;
              resp_q  <= OKAY;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WS;
              ready_q  <= 1'b0;
              resp_q   <= OKAY;
            end
          end else begin
            state   <= S_IDLE;
            ready_q <= 1'b1;
            resp_q  <= OKAY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'h0;
    end else if (state == S_DATA && wr_q) begin
      mem[idx_q] <= bus.HWDATA;
    end
  end

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = (state == S_DATA && !wr_q) ? mem[idx_q] : 32'h0;
endmodule

// File: tb/tb_ahb_mem_slave.sv
// tb/tb_ahb_mem_slave.sv - scoreboard bench for ahb_mem_slave at WAIT_STATES 1, 0 and 3
module tb_ahb_mem_slave;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  dsel = 2'd0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [1:0]  hsize = 2'b10;
  logic [31:0] hwdata = 32'h0;
  logic        force_low = 1'b0;

  logic [2:0]  rdy;
  logic [1:0]  rsp [3];
  logic [31:0] rd  [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          lows;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 3; i++) begin : g_dut
    localparam int WS = (i == 0) ? 1 : (i == 1) ? 0 : 3;
    ahb_mem_slave_if bus ();
    assign bus.HSEL   = hsel && (dsel == 2'(i));
    assign bus.HADDR  = haddr;
    assign bus.HTRANS = htrans;
    assign bus.HWRITE = hwrite;
    assign bus.HSIZE  = hsize;
    assign bus.HWDATA = hwdata;
    assign bus.HREADY = force_low ? 1'b0 : bus.HREADYOUT;
    assign rdy[i]     = bus.HREADYOUT;
    assign rsp[i]     = bus.HRESP;
    assign rd[i]      = bus.HRDATA;

    ahb_mem_slave #(.ADDR_WIDTH(4), .WAIT_STATES(WS)) u_dut (
      .HCLK    (clk),
      .HRESETn (resetn),
      .bus     (bus)
    );
  end

  logic        cur_ready;
  logic [1:0]  cur_resp;
  logic [31:0] cur_rdata;
  logic        hready_eff;
  assign cur_ready  = rdy[dsel];
  assign cur_resp   = rsp[dsel];
  assign cur_rdata  = rd[dsel];
  assign hready_eff = force_low ? 1'b0 : cur_ready;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: tracks data phases from observed accepts and pops the scoreboard at completion
  initial begin : monitor
    bit   active;
    int   lows;
    exp_t e;
    active = 1'b0;
    lows   = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        active = 1'b0;
        lows   = 0;
      end else begin
        if (active) begin
          if (!cur_ready) begin
            lows++;
            if (q.size() > 0) check("wait_resp", 32'(cur_resp), 32'(q[0].resp));
            if (lows > 8) begin
              check("stuck_wait", 32'(lows), 32'd8);
              active = 1'b0;
            end
          end else begin
            if (q.size() == 0) begin
              check("unexpected_completion", 32'd1, 32'd0);
            end else begin
              e = q.pop_front();
              check("wait_cycles", 32'(lows), 32'(e.lows));
              check("final_resp", 32'(cur_resp), 32'(e.resp));
              check("rdata", cur_rdata, e.rdata);
            end
            active = 1'b0;
          end
        end else begin
          check("idle_ready", 32'(cur_ready), 32'd1);
          check("idle_resp", 32'(cur_resp), 32'd0);
          check("idle_rdata", cur_rdata, 32'h0);
        end
        if (hsel && htrans[1] && hready_eff) begin
          active = 1'b1;
          lows   = 0;
        end
      end
    end
  end

  task automatic issue(input logic [1:0] d, input logic [31:0] addr, input logic wr,
                       input logic [1:0] size, input logic [31:0] wdata,
                       input logic [31:0] erd, input logic [1:0] eresp,
                       input int elows, input bit push);
    bit ok;
    int n;
    exp_t e;
    dsel   = d;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    if (push) begin
      e.rdata = erd;
      e.resp  = eresp;
      e.lows  = elows;
      q.push_back(e);
    end
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = hready_eff;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    hwdata = wdata;
    hsel   = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    haddr  = 32'h0;
    hsize  = 2'b10;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset_ready", 32'(rdy[i]), 32'd1);
      check("reset_resp", 32'(rsp[i]), 32'd0);
      check("reset_rdata", rd[i], 32'h0);
    end
    resetn = 1'b1;
    idle(2);

    // WAIT_STATES=1
    issue(2'd0, 32'hC200_0000, 1'b0, 2'b10, 32'h0,         32'h0,         2'b00, 1, 1);
    issue(2'd0, 32'hC200_0010, 1'b1, 2'b10, 32'h0000_1234, 32'h0,         2'b00, 1, 1);
    issue(2'd0, 32'hC200_0010, 1'b0, 2'b10, 32'h0,         32'h0000_1234, 2'b00, 1, 1);
    idle(3);

    // Error responses, back-to-back, then confirm memory untouched
    issue(2'd0, 32'hC200_0040, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'h0, 2'b01, 1, 1);
    issue(2'd0, 32'hC200_0004, 1'b1, 2'b01, 32'h1111_1111, 32'h0, 2'b01, 1, 1);
    issue(2'd0, 32'hC200_0002, 1'b1, 2'b10, 32'h2222_2222, 32'h0, 2'b01, 1, 1);
    issue(2'd0, 32'hC200_0000, 1'b0, 2'b10, 32'h0, 32'h0,         2'b00, 1, 1);
    issue(2'd0, 32'hC200_0004, 1'b0, 2'b10, 32'h0, 32'h0,         2'b00, 1, 1);
    issue(2'd0, 32'hC200_0010, 1'b0, 2'b10, 32'h0, 32'h0000_1234, 2'b00, 1, 1);
    idle(3);

    // BUSY and HREADY=0 must not be accepted
    dsel   = 2'd0;
    hsel   = 1'b1;
    htrans = 2'b01;
    haddr  = 32'hC200_0008;
    hwrite = 1'b1;
    hwdata = 32'h7777_7777;
    idle(3);
    htrans    = 2'b10;
    force_low = 1'b1;
    idle(3);
    force_low = 1'b0;
    hsel      = 1'b0;
    htrans    = 2'b00;
    hwrite    = 1'b0;
    idle(2);
    issue(2'd0, 32'hC200_0008, 1'b0, 2'b10, 32'h0, 32'h0, 2'b00, 1, 1);
    idle(3);

    // WAIT_STATES=0
    issue(2'd1, 32'hC200_003C, 1'b1, 2'b10, 32'hDEAD_BEEF, 32'h0,         2'b00, 0, 1);
    issue(2'd1, 32'hC200_003C, 1'b0, 2'b10, 32'h0,         32'hDEAD_BEEF, 2'b00, 0, 1);
    issue(2'd1, 32'hC200_0080, 1'b1, 2'b10, 32'h3333_3333, 32'h0,         2'b01, 1, 1);
    issue(2'd1, 32'hC200_0000, 1'b0, 2'b10, 32'h0,         32'h0,         2'b00, 0, 1);
    idle(3);

    // WAIT_STATES=3, then reset during the second wait cycle of a write
    issue(2'd2, 32'hC200_000C, 1'b1, 2'b10, 32'h0000_A5A5, 32'h0,         2'b00, 3, 1);
    issue(2'd2, 32'hC200_000C, 1'b0, 2'b10, 32'h0,         32'h0000_A5A5, 2'b00, 3, 1);
    idle(2);
    issue(2'd2, 32'hC200_0008, 1'b1, 2'b10, 32'h5555_AAAA, 32'h0, 2'b00, 3, 0);
    @(posedge clk);
    #1;
    check("wait_before_reset", 32'(cur_ready), 32'd0);
    resetn = 1'b0;
    #1;
    check("midreset_ready", 32'(cur_ready), 32'd1);
    check("midreset_resp", 32'(cur_resp), 32'd0);
    check("midreset_rdata", cur_rdata, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(2);
    issue(2'd2, 32'hC200_0008, 1'b0, 2'b10, 32'h0, 32'h0, 2'b00, 3, 1);
    issue(2'd2, 32'hC200_000C, 1'b0, 2'b10, 32'h0, 32'h0, 2'b00, 3, 1);
    idle(3);
    issue(2'd0, 32'hC200_0010, 1'b0, 2'b10, 32'h0, 32'h0, 2'b00, 1, 1);
    idle(4);

    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
